// File: rtl/gem_frame_formatter.sv
// Per-fiber GEM trigger-link framer: turns one 56-bit link word per BX into four
// 16-bit K-flagged transmitter words, with startup idles and periodic latency markers.
module gem_frame_formatter #(
  parameter int SYNC_FRAMES   = 16,
  parameter int MARKER_PERIOD = 128
) (
  input  logic        clk_160,
  input  logic        reset,
  input  logic [55:0] link_data,
  input  logic        overflow,
  input  logic        ena_test_pat,
  input  logic        tx_pll_lock,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_isk,
  output logic        ltncy_trig,
  output logic        strt_ltncy,
  output logic        link_ready
);

  typedef enum logic [1:0] {WAIT_LOCK, SYNC, RUN} state_t;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K28_7     = 8'hFC;
  localparam logic [7:0] K23_7     = 8'hF7;
  localparam logic [7:0] FC_MASK   = 8'(MARKER_PERIOD - 1);
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_FRAMES - 1);

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [7:0]  fc_q, fc_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d;
  logic [55:0] shadow_q, shadow_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [1:0]  tx_isk_q, tx_isk_d;
  logic        ltncy_q, ltncy_d;
  logic        strt_q, strt_d;
  logic        ready_q, ready_d;

  logic        frame_run;
  logic        frame_first;
  logic [7:0]  comma;
  logic [55:0] frame_d;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    ph_d        = ph_q + 2'd1;
    state_d     = state_q;
    fc_d        = fc_q;
    sync_cnt_d  = sync_cnt_q;
    frame_run   = 1'b0;
    frame_first = 1'b0;

    if (ph_q == 2'd3) begin
      case (state_q)
        WAIT_LOCK: if (tx_pll_lock) begin
          state_d    = SYNC;
          sync_cnt_d = 8'd0;
        end
        SYNC: if (!tx_pll_lock) begin
          state_d = WAIT_LOCK;
        end else if (sync_cnt_q == SYNC_LAST) begin
          state_d     = RUN;
          frame_run   = 1'b1;
          frame_first = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q + 8'd1;
        end
        RUN: if (!tx_pll_lock) state_d = WAIT_LOCK;
             else              frame_run = 1'b1;
        default: state_d = WAIT_LOCK;
      endcase
      // fc rests at zero outside RUN so every entry starts with a marker frame
      fc_d = frame_run ? ((fc_q + 8'd1) & FC_MASK) : 8'd0;
    end

    frame_d = '0;
    comma   = K28_5;
    if (frame_run) begin
      frame_d = ena_test_pat ? {7{fc_q}} : link_data;
      if (fc_q == 8'd0)  comma = K28_7;
      else if (overflow) comma = K23_7;
    end

    shadow_d  = shadow_q;
    tx_data_d = tx_data_q;
    tx_isk_d  = 2'b00;
    ltncy_d   = 1'b0;
    strt_d    = 1'b0;
    ready_d   = ready_q;
    case (ph_q)
      2'd3: begin
        shadow_d  = frame_d;
        tx_data_d = {frame_d[7:0], comma};
        tx_isk_d  = 2'b01;
        ltncy_d   = frame_run && (fc_q == 8'd0);
        strt_d    = frame_first;
        ready_d   = frame_run;
      end
      2'd0:    tx_data_d = shadow_q[23:8];
      2'd1:    tx_data_d = shadow_q[39:24];
      default: tx_data_d = shadow_q[55:40];
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from
  // the same pre-edge values.
  always_ff @(posedge clk_160) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      ph_q       <= 2'd0;
      fc_q       <= 8'd0;
      sync_cnt_q <= 8'd0;
      // cleared so the frame shown straight out of reset is a clean idle frame
      shadow_q   <= '0;
      tx_data_q  <= {8'h00, K28_5};
      tx_isk_q   <= 2'b01;
      ltncy_q    <= 1'b0;
      strt_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      fc_q       <= fc_d;
      sync_cnt_q <= sync_cnt_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_isk_q   <= tx_isk_d;
      ltncy_q    <= ltncy_d;
      strt_q     <= strt_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_isk     = tx_isk_q;
  assign ltncy_trig = ltncy_q;
  assign strt_ltncy = strt_q;
  assign link_ready = ready_q;

endmodule
